// File: rtl/scan_index_sequencer.sv
// scan_index_sequencer
//   Generates the 3-bit select (a2 a1 a0) for a downstream 3-to-8 one-hot
//   decoder and steps it once every DIVISOR enabled clock cycles. Patterns:
//   hold, count-up, count-down and bounce (ping-pong). A synchronous load
//   places an arbitrary index and restarts the step period.
//
// Parameters
//   DIVISOR : enabled clk cycles per step (>= 1)
//   CNT_W   : prescaler width, 2**CNT_W >= DIVISOR
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-high reset
//   en       : prescaler run enable (0 freezes prescaler and index)
//   mode     : 00 hold, 01 up, 10 down, 11 bounce
//   load     : synchronous load strobe (beats a coincident step)
//   load_val : index applied on load
//   a0/a1/a2 : registered index bits, wired straight to the decoder
//   tick     : one-cycle pulse in the first cycle a new step result is visible
//   wrap     : one-cycle pulse with tick on a modulo wrap or bounce endpoint
module scan_index_sequencer #(
  parameter int unsigned DIVISOR = 25000000,
  parameter int unsigned CNT_W   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [CNT_W-1:0] presc;
  logic [2:0]       idx;
  dir_t             dir;

  logic [2:0] nxt_idx;
  dir_t       nxt_dir;
  logic       nxt_wrap;
  logic       step_due;

  assign step_due = en && (presc == CNT_W'(DIVISOR - 1));

  // Index/direction that a step taken now would produce.
  always_comb begin
    nxt_idx  = idx;
    nxt_dir  = dir;
    nxt_wrap = 1'b0;
    case (mode_t'(mode))
      MODE_HOLD: begin
        nxt_idx = idx;
      end
      MODE_UP: begin
        nxt_idx  = idx + 3'd1;
        nxt_wrap = (idx == 3'd7);
      end
      MODE_DOWN: begin
        nxt_idx  = idx - 3'd1;
        nxt_wrap = (idx == 3'd0);
      end
      MODE_BOUNCE: begin
        // Endpoint is flagged on arrival; leaving an endpoint only turns the
        // direction (needed when dir and index disagree after up/down/load).
        if (dir == DIR_UP) begin
          if (idx == 3'd7) begin
            nxt_idx = 3'd6;
            nxt_dir = DIR_DOWN;
          end else begin
            nxt_idx = idx + 3'd1;
            if (idx == 3'd6) begin
              nxt_dir  = DIR_DOWN;
              nxt_wrap = 1'b1;
            end
          end
        end else begin
          if (idx == 3'd0) begin
            nxt_idx = 3'd1;
            nxt_dir = DIR_UP;
          end else begin
            nxt_idx = idx - 3'd1;
            if (idx == 3'd1) begin
              nxt_dir  = DIR_UP;
              nxt_wrap = 1'b1;
            end
          end
        end
      end
      default: begin
        nxt_idx = idx;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      dir   <= DIR_UP;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        idx   <= load_val;
        presc <= '0;
        dir   <= DIR_UP;
      end else if (step_due) begin
        presc <= '0;
        idx   <= nxt_idx;
        dir   <= nxt_dir;
        tick  <= 1'b1;
        wrap  <= nxt_wrap;
      end else if (en) begin
        presc <= presc + CNT_W'(1);
      end
    end
  end

  assign a0 = idx[0];
  assign a1 = idx[1];
  assign a2 = idx[2];

endmodule
